// File: rtl/asi_pkg.sv
// rtl/asi_pkg.sv - AXI field widths, burst types and master-write shared types
package asi_pkg;
  localparam int AXI_IW     = 4;
  localparam int AXI_AW     = 32;
  localparam int AXI_LW     = 8;
  localparam int AXI_SW     = 3;
  localparam int AXI_BURSTW = 2;
  localparam int AXI_DW     = 32;
  localparam int AXI_WSTRBW = AXI_DW / 8;
  localparam int AXI_BRESPW = 2;

  localparam logic [AXI_BURSTW-1:0] BT_FIXED    = 2'b00;
  localparam logic [AXI_BURSTW-1:0] BT_INCR     = 2'b01;
  localparam logic [AXI_BURSTW-1:0] BT_WRAP     = 2'b10;
  localparam logic [AXI_BURSTW-1:0] BT_RESERVED = 2'b11;

  localparam int MST_OD_DFLT = 4;
  localparam int MST_BYTEW   = AXI_DW / 8;

  typedef enum logic {W_IDLE, W_BURST} w_phase_e;
endpackage

// File: rtl/sfifo.sv
// rtl/sfifo.sv - single-clock show-ahead FIFO with registered empty/full
module sfifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt, cnt_nx;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_comb begin
    cnt_nx = cnt;
    if (do_push & ~do_pop)      cnt_nx = cnt + 1'b1;
    else if (~do_push & do_pop) cnt_nx = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt   <= cnt_nx;
      empty <= (cnt_nx == '0);
      full  <= (cnt_nx == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/ami_w.sv
// rtl/ami_w.sv - AXI4 master write interface with in-order outstanding bursts
module ami_w
  import asi_pkg::*;
#(
  parameter int MST_OD = MST_OD_DFLT
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  output logic [AXI_IW-1:0]     AWID,
  output logic [AXI_AW-1:0]     AWADDR,
  output logic [AXI_LW-1:0]     AWLEN,
  output logic [AXI_SW-1:0]     AWSIZE,
  output logic [AXI_BURSTW-1:0] AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [AXI_DW-1:0]     WDATA,
  output logic [AXI_WSTRBW-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [AXI_IW-1:0]     BID,
  input  logic [AXI_BRESPW-1:0] BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [AXI_IW-1:0]     u_cmd_id,
  input  logic [AXI_AW-1:0]     u_cmd_addr,
  input  logic [AXI_LW-1:0]     u_cmd_len,
  input  logic [AXI_SW-1:0]     u_cmd_size,
  input  logic [AXI_BURSTW-1:0] u_cmd_burst,
  input  logic                  u_cmd_valid,
  output logic                  u_cmd_ready,
  output logic                  u_cmd_err,
  input  logic [AXI_DW-1:0]     u_wdata,
  input  logic [AXI_WSTRBW-1:0] u_wstrb,
  input  logic                  u_wvalid,
  output logic                  u_wready,
  output logic [AXI_IW-1:0]     u_bid,
  output logic [AXI_BRESPW-1:0] u_bresp,
  output logic                  u_bvalid,
  input  logic                  u_bready,
  output logic                  u_busy
);
  localparam int CW       = $clog2(MST_OD + 1);
  localparam int SIZE_MAX = $clog2(MST_BYTEW);

  logic [CW-1:0]     cnt;
  logic              cmd_acc, cmd_bad, cmd_ok, b_hs;
  logic              lff_pop, lff_empty, lff_full;
  logic [AXI_LW-1:0] lff_rdata;
  w_phase_e          w_q, w_nx;
  logic [AXI_LW-1:0] beat_q, beat_nx, len_q, len_nx;

  assign u_cmd_ready = ~(AWVALID & ~AWREADY) & (cnt < CW'(MST_OD)) & ~lff_full;
  assign cmd_acc     = u_cmd_valid & u_cmd_ready;
  assign cmd_bad     = (u_cmd_size > AXI_SW'(SIZE_MAX)) | (u_cmd_burst == BT_RESERVED);
  assign cmd_ok      = cmd_acc & ~cmd_bad;
  assign BREADY      = ~u_bvalid | u_bready;
  assign b_hs        = BVALID & BREADY;
  assign u_busy      = (cnt != '0) | AWVALID;
  assign WDATA       = u_wdata;
  assign WSTRB       = u_wstrb;

  sfifo #(.AW($clog2(MST_OD)), .DW(AXI_LW)) u_len_fifo (
    .clk(ACLK), .resetn(ARESETn), .push(cmd_ok), .wdata(u_cmd_len),
    .pop(lff_pop), .rdata(lff_rdata), .empty(lff_empty), .full(lff_full)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      AWVALID <= 1'b0;
      AWID <= '0; AWADDR <= '0; AWLEN <= '0; AWSIZE <= '0; AWBURST <= '0;
      u_cmd_err <= 1'b0;
      u_bvalid <= 1'b0; u_bid <= '0; u_bresp <= '0;
      cnt <= '0;
    end else begin
      u_cmd_err <= cmd_acc & cmd_bad;
      if (cmd_ok) begin
        AWVALID <= 1'b1;
        AWID <= u_cmd_id; AWADDR <= u_cmd_addr; AWLEN <= u_cmd_len;
        AWSIZE <= u_cmd_size; AWBURST <= u_cmd_burst;
      end else if (AWREADY) begin
        AWVALID <= 1'b0;
      end
      if (b_hs) begin
        u_bvalid <= 1'b1; u_bid <= BID; u_bresp <= BRESP;
      end else if (u_bready) begin
        u_bvalid <= 1'b0;
      end
      // A stray B at zero outstanding is forwarded but must not wrap the count
      if (cmd_ok && !(b_hs && cnt != '0))      cnt <= cnt + 1'b1;
      else if (!cmd_ok && b_hs && cnt != '0)  cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_q <= W_IDLE; beat_q <= '0; len_q <= '0;
    end else begin
      w_q <= w_nx; beat_q <= beat_nx; len_q <= len_nx;
    end
  end

  always_comb begin
    w_nx = w_q; beat_nx = beat_q; len_nx = len_q;
    lff_pop = 1'b0; WVALID = 1'b0; u_wready = 1'b0; WLAST = 1'b0;
    case (w_q)
      W_IDLE: if (!lff_empty) begin
        lff_pop = 1'b1; beat_nx = '0; len_nx = lff_rdata; w_nx = W_BURST;
      end
      W_BURST: begin
        WVALID = u_wvalid; u_wready = WREADY; WLAST = (beat_q == len_q);
        if (u_wvalid & WREADY) begin
          if (WLAST) begin
            // Reload straight from the FIFO so consecutive bursts have no bubble
            if (!lff_empty) begin
              lff_pop = 1'b1; beat_nx = '0; len_nx = lff_rdata;
            end else begin
              w_nx = W_IDLE;
            end
          end else begin
            beat_nx = beat_q + 1'b1;
          end
        end
      end
      default: w_nx = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ami_w.sv
// tb/tb_ami_w.sv - directed self-checking bench for ami_w
module tb_ami_w;
  import asi_pkg::*;

  logic                  ACLK = 1'b0, ARESETn = 1'b0;
  logic [AXI_IW-1:0]     AWID;
  logic [AXI_AW-1:0]     AWADDR;
  logic [AXI_LW-1:0]     AWLEN;
  logic [AXI_SW-1:0]     AWSIZE;
  logic [AXI_BURSTW-1:0] AWBURST;
  logic                  AWVALID, AWREADY = 1'b0;
  logic [AXI_DW-1:0]     WDATA;
  logic [AXI_WSTRBW-1:0] WSTRB;
  logic                  WLAST, WVALID, WREADY = 1'b0;
  logic [AXI_IW-1:0]     BID = '0;
  logic [AXI_BRESPW-1:0] BRESP = '0;
  logic                  BVALID = 1'b0, BREADY;
  logic [AXI_IW-1:0]     u_cmd_id = '0;
  logic [AXI_AW-1:0]     u_cmd_addr = '0;
  logic [AXI_LW-1:0]     u_cmd_len = '0;
  logic [AXI_SW-1:0]     u_cmd_size = 3'd2;
  logic [AXI_BURSTW-1:0] u_cmd_burst = BT_INCR;
  logic                  u_cmd_valid = 1'b0, u_cmd_ready, u_cmd_err;
  logic [AXI_DW-1:0]     u_wdata = '0;
  logic [AXI_WSTRBW-1:0] u_wstrb = '1;
  logic                  u_wvalid = 1'b0, u_wready;
  logic [AXI_IW-1:0]     u_bid;
  logic [AXI_BRESPW-1:0] u_bresp;
  logic                  u_bvalid, u_bready = 1'b1, u_busy;

  int errors = 0, checks = 0, beats;

  ami_w #(.MST_OD(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .u_cmd_id(u_cmd_id), .u_cmd_addr(u_cmd_addr), .u_cmd_len(u_cmd_len),
    .u_cmd_size(u_cmd_size), .u_cmd_burst(u_cmd_burst),
    .u_cmd_valid(u_cmd_valid), .u_cmd_ready(u_cmd_ready), .u_cmd_err(u_cmd_err),
    .u_wdata(u_wdata), .u_wstrb(u_wstrb), .u_wvalid(u_wvalid), .u_wready(u_wready),
    .u_bid(u_bid), .u_bresp(u_bresp), .u_bvalid(u_bvalid), .u_bready(u_bready),
    .u_busy(u_busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    step(); step();
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_bvalid", u_bvalid, 0);
    chk("rst_err", u_cmd_err, 0);
    chk("rst_busy", u_busy, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_ready", u_cmd_ready, 1);
    ARESETn = 1'b1;
    step();

    // single beat
    u_cmd_id = 4'd3; u_cmd_addr = 32'h100; u_cmd_len = 8'd0; u_cmd_size = 3'd2;
    u_cmd_burst = BT_INCR; u_cmd_valid = 1'b1; AWREADY = 1'b1;
    step();
    u_cmd_valid = 1'b0;
    chk("s_awvalid", AWVALID, 1);
    chk("s_awaddr", AWADDR, 32'h100);
    chk("s_awid", AWID, 3);
    chk("s_awlen", AWLEN, 0);
    chk("s_busy", u_busy, 1);
    u_wvalid = 1'b1; u_wdata = 32'hDEADBEEF; WREADY = 1'b1;
    #1;
    chk("s_w_early", WVALID, 0);
    step();
    chk("s_aw_done", AWVALID, 0);
    chk("s_wvalid", WVALID, 1);
    chk("s_wlast", WLAST, 1);
    chk("s_wdata", WDATA, 32'hDEADBEEF);
    step();
    u_wvalid = 1'b0;
    chk("s_w_idle", WVALID, 0);
    BVALID = 1'b1; BID = 4'd3; BRESP = 2'd0; u_bready = 1'b0;
    #1;
    chk("s_bready", BREADY, 1);
    step();
    BVALID = 1'b0;
    chk("s_ubvalid", u_bvalid, 1);
    chk("s_ubid", u_bid, 3);
    chk("s_ubresp", u_bresp, 0);
    chk("s_busy_end", u_busy, 0);
    chk("s_bready_hold", BREADY, 0);
    u_bready = 1'b1;
    step();
    chk("s_ubvalid_clr", u_bvalid, 0);

    // 4-beat INCR, AWREADY low 5 cycles, WREADY toggling
    u_cmd_id = 4'd5; u_cmd_addr = 32'h2000; u_cmd_len = 8'd3;
    u_cmd_valid = 1'b1; AWREADY = 1'b0; WREADY = 1'b0; u_wvalid = 1'b1;
    step();
    u_cmd_valid = 1'b0;
    chk("i_ready_stall", u_cmd_ready, 0);
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      AWREADY = (c == 5);
      WREADY = c[0];
      u_wdata = 32'hA0 + beats;
      #1;
      if (c <= 5) begin
        chk("i_awvalid_hold", AWVALID, 1);
        chk("i_awaddr_hold", AWADDR, 32'h2000);
        chk("i_awlen_hold", AWLEN, 3);
      end
      if (WVALID && WREADY) begin
        chk("i_wlast", WLAST, (beats == 3));
        chk("i_wdata", WDATA, 32'hA0 + beats);
        beats++;
      end
      step();
    end
    chk("i_beats", beats, 4);
    chk("i_w_idle", WVALID, 0);
    chk("i_aw_done", AWVALID, 0);
    u_wvalid = 1'b0; AWREADY = 1'b0;
    BVALID = 1'b1; BID = 4'd5; BRESP = 2'd2;
    step();
    BVALID = 1'b0;
    chk("i_bresp_slverr", u_bresp, 2);
    chk("i_bid", u_bid, 5);
    step();

    // outstanding limit
    AWREADY = 1'b1; u_cmd_len = 8'd0; u_cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_cmd_id = 4'(i);
      #1;
      chk("o_ready_free", u_cmd_ready, 1);
      step();
    end
    chk("o_ready_full", u_cmd_ready, 0);
    step();
    chk("o_ready_full2", u_cmd_ready, 0);
    BVALID = 1'b1; BID = 4'd0;
    step();
    BVALID = 1'b0;
    chk("o_ready_after_b", u_cmd_ready, 1);
    step();
    u_cmd_valid = 1'b0;
    chk("o_fifth_aw", AWVALID, 1);
    chk("o_ready_full3", u_cmd_ready, 0);
    u_wvalid = 1'b1; WREADY = 1'b1;
    for (int i = 0; i < 7; i++) step();
    BVALID = 1'b1;
    for (int i = 0; i < 4; i++) step();
    BVALID = 1'b0;
    step();
    chk("o_drained_busy", u_busy, 0);
    chk("o_drained_w", WVALID, 0);

    // back-to-back len=1 bursts
    u_cmd_len = 8'd1; u_cmd_id = 4'd1; u_cmd_valid = 1'b1;
    step();
    u_cmd_id = 4'd2;
    step();
    u_cmd_valid = 1'b0;
    chk("bb_a0_valid", WVALID, 1);
    chk("bb_a0_last", WLAST, 0);
    step();
    chk("bb_a1_last", WLAST, 1);
    step();
    chk("bb_b0_valid", WVALID, 1);
    chk("bb_b0_last", WLAST, 0);
    step();
    chk("bb_b1_last", WLAST, 1);
    step();
    chk("bb_idle", WVALID, 0);

    // simultaneous cmd accept and B at count=2
    u_wvalid = 1'b0; u_cmd_len = 8'd0; u_cmd_id = 4'd3; u_cmd_valid = 1'b1;
    BVALID = 1'b1; BID = 4'd1;
    #1;
    chk("sim_ready", u_cmd_ready, 1);
    step();
    BVALID = 1'b0;
    chk("sim_cnt2_a", u_cmd_ready, 1);
    step();
    chk("sim_cnt2_b", u_cmd_ready, 1);
    step();
    chk("sim_cnt4", u_cmd_ready, 0);
    u_cmd_valid = 1'b0;

    // reset to clean state, then illegal commands
    ARESETn = 1'b0;
    step(); step();
    ARESETn = 1'b1;
    chk("r_busy", u_busy, 0);
    AWREADY = 1'b0; u_wvalid = 1'b1; WREADY = 1'b1;
    u_cmd_size = 3'd3; u_cmd_burst = BT_INCR; u_cmd_valid = 1'b1;
    #1;
    chk("ill_ready", u_cmd_ready, 1);
    step();
    u_cmd_valid = 1'b0;
    chk("ill_size_err", u_cmd_err, 1);
    chk("ill_size_aw", AWVALID, 0);
    chk("ill_size_busy", u_busy, 0);
    step();
    chk("ill_err_pulse", u_cmd_err, 0);
    chk("ill_no_w", WVALID, 0);
    u_cmd_size = 3'd2; u_cmd_burst = BT_RESERVED; u_cmd_valid = 1'b1;
    step();
    u_cmd_valid = 1'b0;
    chk("ill_burst_err", u_cmd_err, 1);
    chk("ill_burst_aw", AWVALID, 0);
    step();
    chk("ill_burst_pulse", u_cmd_err, 0);
    chk("ill_burst_w", WVALID, 0);
    chk("ill_busy", u_busy, 0);

    // reset mid 8-beat burst
    u_cmd_burst = BT_INCR; u_cmd_len = 8'd7; u_cmd_id = 4'd6; u_cmd_valid = 1'b1;
    u_bready = 1'b0;
    step();
    u_cmd_valid = 1'b0;
    BVALID = 1'b1; BID = 4'd1;
    step();
    BVALID = 1'b0;
    step(); step(); step();
    chk("mr_beat3_w", WVALID, 1);
    chk("mr_beat3_last", WLAST, 0);
    chk("mr_pre_bvalid", u_bvalid, 1);
    ARESETn = 1'b0;
    step();
    ARESETn = 1'b1;
    chk("mr_awvalid", AWVALID, 0);
    chk("mr_wvalid", WVALID, 0);
    chk("mr_bvalid", u_bvalid, 0);
    chk("mr_busy", u_busy, 0);

    // fresh command after reset
    u_bready = 1'b1; AWREADY = 1'b1; u_cmd_len = 8'd0; u_cmd_id = 4'd7; u_cmd_valid = 1'b1;
    step();
    u_cmd_valid = 1'b0;
    chk("f_awvalid", AWVALID, 1);
    chk("f_awid", AWID, 7);
    step();
    chk("f_wvalid", WVALID, 1);
    chk("f_wlast", WLAST, 1);
    step();
    BVALID = 1'b1; BID = 4'd7; BRESP = 2'd3;
    step();
    BVALID = 1'b0;
    chk("f_ubvalid", u_bvalid, 1);
    chk("f_ubresp", u_bresp, 3);
    chk("f_ubid", u_bid, 7);
    step();
    chk("f_busy", u_busy, 0);
    chk("f_ubvalid_clr", u_bvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
